// File: rtl/genius_pkg.sv
// Shared types and helpers for the genius memory-game engine.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW_ON  = 3'd1,
    ST_SHOW_GAP = 3'd2,
    ST_INPUT    = 3'd3,
    ST_LEVEL_UP = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  localparam int unsigned LFSR_W       = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit sequence generator: load a seed or advance one step per request.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= load_val_i;
    end else if (step_i) begin
      state_q <= lfsr_advance(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/genius_engine.sv
// Memory-game engine: replays a seeded pseudo-random sequence and checks the player's presses.
// Define GENIUS_TIMEOUT_EN to make TIMEOUT_TICKS idle ticks in INPUT lose the game.
module genius_engine
  import genius_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 4,
  parameter int unsigned MAX_LEVEL     = 16,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 64,
  localparam int unsigned SYM_W        = width_of(NUM_BTN),
  localparam int unsigned LVL_W        = $clog2(MAX_LEVEL + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic [NUM_BTN-1:0] btn,
  output logic               show_valid,
  output logic [SYM_W-1:0]   show_sym,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   progress,
  output logic [2:0]         state_o,
  output logic               win,
  output logic               lose
);

  localparam int unsigned MAX_SG    = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
  localparam int unsigned CNT_W     = width_of(MAX_TICKS);

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  progress_q, progress_d;
  logic [LVL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       seed_q, seed_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              show_valid_q, show_valid_d;
  logic [SYM_W-1:0]  show_sym_q, show_sym_d;

  logic              lfsr_load, lfsr_step;
  logic [15:0]       lfsr_ld_val, lfsr_q;
  logic [SYM_W-1:0]  nxt_raw;
  logic [NUM_BTN-1:0] exp_oh;

  // Fold the raw LFSR bits into the legal symbol range
  function automatic logic [SYM_W-1:0] sym_of(input logic [SYM_W-1:0] raw);
    if (32'(raw) >= NUM_BTN) begin
      return raw - SYM_W'(NUM_BTN);
    end
    return raw;
  endfunction

  genius_lfsr u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_ld_val),
    .step_i     (lfsr_step),
    .state_o    (lfsr_q)
  );

  assign exp_oh = NUM_BTN'(1) << sym_of(lfsr_q[SYM_W-1:0]);

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    progress_d  = progress_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    win_d       = win_q;
    lose_d      = lose_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    lfsr_ld_val = seed_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          seed_d      = (seed == '0) ? DEFAULT_SEED : seed;
          level_d     = LVL_W'(1);
          progress_d  = '0;
          idx_d       = '0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          lfsr_load   = 1'b1;
          lfsr_ld_val = seed_d;
          state_d     = ST_SHOW_ON;
        end
      end
      ST_SHOW_ON: begin
        if (tick) begin
          if (cnt_q == CNT_W'(SHOW_TICKS - 1)) begin
            lfsr_step = 1'b1;
            idx_d     = idx_q + LVL_W'(1);
            state_d   = ST_SHOW_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SHOW_GAP: begin
        if (tick) begin
          if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
            if (idx_q == level_q) begin
              lfsr_load = 1'b1;
              state_d   = ST_INPUT;
            end else begin
              state_d = ST_SHOW_ON;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_INPUT: begin
`ifdef GENIUS_TIMEOUT_EN
        if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        if (btn != '0) begin
          if (btn == exp_oh) begin
            progress_d = progress_q + LVL_W'(1);
            lfsr_step  = 1'b1;
            cnt_d      = '0;
            if (progress_d == level_q) begin
              state_d = ST_LEVEL_UP;
            end
          end else begin
            lose_d  = 1'b1;
            state_d = ST_LOSE;
          end
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (tick && (cnt_q == CNT_W'(TIMEOUT_TICKS - 1))) begin
          lose_d  = 1'b1;
          state_d = ST_LOSE;
        end
`endif
      end
      ST_LEVEL_UP: begin
        if (level_q == LVL_W'(MAX_LEVEL)) begin
          win_d   = 1'b1;
          state_d = ST_WIN;
        end else begin
          level_d    = level_q + LVL_W'(1);
          progress_d = '0;
          idx_d      = '0;
          lfsr_load  = 1'b1;
          state_d    = ST_SHOW_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Register the display from the LFSR value that will be current in the next state
    if (lfsr_load) begin
      nxt_raw = lfsr_ld_val[SYM_W-1:0];
    end else if (lfsr_step) begin
      nxt_raw = SYM_W'(lfsr_advance(lfsr_q));
    end else begin
      nxt_raw = lfsr_q[SYM_W-1:0];
    end
    show_valid_d = (state_d == ST_SHOW_ON);
    show_sym_d   = show_valid_d ? sym_of(nxt_raw) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      progress_q   <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      seed_q       <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      show_valid_q <= 1'b0;
      show_sym_q   <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      progress_q   <= progress_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      seed_q       <= seed_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      show_valid_q <= show_valid_d;
      show_sym_q   <= show_sym_d;
    end
  end

  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign level      = level_q;
  assign progress   = progress_q;
  assign state_o    = state_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_genius_engine.sv
// Bench for genius_engine: table of games plus directed reset, restart and timeout sequences.
module tb_genius_engine;

  localparam int unsigned NB = 3;
  localparam int unsigned ML = 2;
  localparam int unsigned LW = 2;

  logic          clock, reset, tick, start;
  logic [15:0]   seed;
  logic [NB-1:0] btn;
  logic          show_valid;
  logic [1:0]    show_sym;
  logic [LW-1:0] level, progress;
  logic [2:0]    state_o;
  logic          win, lose;

  logic tick_auto, tick_gen, tick_man;
  int   total, bad;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [15:0] seed;
    int          fail_at;
    bit          two_bits;
    bit          inject;
    int          exp_win;
    int          exp_lose;
    int          exp_level;
    int          exp_prog;
    int          exp_state;
  } game_t;

  game_t       games[7];
  logic [15:0] sr_t;
  logic [1:0]  s_t;
  bit          ok_t;

  assign tick = tick_auto ? tick_gen : tick_man;

  genius_engine #(
    .NUM_BTN       (NB),
    .MAX_LEVEL     (ML),
    .SHOW_TICKS    (2),
    .GAP_TICKS     (1),
    .TIMEOUT_TICKS (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .seed       (seed),
    .btn        (btn),
    .show_valid (show_valid),
    .show_sym   (show_sym),
    .level      (level),
    .progress   (progress),
    .state_o    (state_o),
    .win        (win),
    .lose       (lose)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    tick_gen = 1'b0;
    forever begin
      @(negedge clock);
      tick_gen = ~tick_gen;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_sym(input logic [15:0] sr, input int k);
    logic [15:0] v;
    logic [1:0]  raw;
    v = sr;
    for (int i = 0; i < k; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    raw = v[1:0];
    return (raw == 2'd3) ? 2'd0 : raw;
  endfunction

  function automatic logic [NB-1:0] onehot(input int s);
    return NB'(1 << s);
  endfunction

  task automatic push_round(input logic [15:0] sr, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model_sym(sr, k));
  endtask

  task automatic wait_state(input int target, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (int'(state_o) == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: state %0d never reached, stuck at %0d", name, target, int'(state_o));
    end
  endtask

  // Scoreboard: every new displayed symbol must match the next queued expectation
  initial begin
    logic       prev_sv;
    logic [1:0] e;
    prev_sv = 1'b0;
    forever begin
      @(negedge clock);
      if (show_valid && !prev_sv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL show_extra: got symbol %0d with nothing expected", int'(show_sym));
        end else begin
          e = exp_q.pop_front();
          chk("show_sym", int'(show_sym), int'(e));
        end
      end
      if (!show_valid && prev_sv) chk("sym_blank", int'(show_sym), 0);
      prev_sv = show_valid;
    end
  end

  task automatic play(input game_t g);
    logic [15:0] sr;
    logic [1:0]  s;
    int          press_no;
    bit          done, ok;
    sr = (g.seed == 16'h0000) ? 16'hACE1 : g.seed;
    push_round(sr, 1);
    seed  = g.seed;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_state", int'(state_o), 1);
    chk("start_level", int'(level), 1);
    chk("start_prog", int'(progress), 0);
    chk("start_flags", int'({win, lose}), 0);
    if (g.inject) begin
      seed  = g.seed ^ 16'h0001;
      start = 1'b1;
      btn   = '1;
      @(negedge clock);
      start = 1'b0;
      btn   = '0;
      seed  = g.seed;
      chk("inject_state", int'(state_o), 1);
      chk("inject_lose", int'(lose), 0);
    end
    press_no = 0;
    done     = 1'b0;
    for (int lvl = 1; lvl <= int'(ML) && !done; lvl++) begin
      wait_state(3, "to_input", ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      for (int k = 0; k < lvl; k++) begin
        s = model_sym(sr, k);
        if (press_no == g.fail_at) begin
          btn = g.two_bits ? (onehot(int'(s)) | onehot((int'(s) + 1) % 3)) : onehot((int'(s) + 1) % 3);
          @(negedge clock);
          btn = '0;
          chk("lose_next", int'(lose), 1);
          done = 1'b1;
          break;
        end
        btn = onehot(int'(s));
        @(negedge clock);
        btn = '0;
        chk("progress", int'(progress), k + 1);
        press_no++;
        if (k == lvl - 1 && lvl < int'(ML)) push_round(sr, lvl + 1);
      end
    end
    if (!done) wait_state(5, "to_win", ok);
    chk("end_win", int'(win), g.exp_win);
    chk("end_lose", int'(lose), g.exp_lose);
    chk("end_level", int'(level), g.exp_level);
    chk("end_prog", int'(progress), g.exp_prog);
    chk("end_state", int'(state_o), g.exp_state);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    seed      = '0;
    btn       = '0;
    tick_auto = 1'b1;
    tick_man  = 1'b0;

    games[0] = '{16'h1234, -1, 1'b0, 1'b1, 1, 0, 2, 2, 5};
    games[1] = '{16'h0000, -1, 1'b0, 1'b0, 1, 0, 2, 2, 5};
    games[2] = '{16'hACE1, -1, 1'b0, 1'b0, 1, 0, 2, 2, 5};
    games[3] = '{16'hBEEF,  0, 1'b0, 1'b0, 0, 1, 1, 0, 6};
    games[4] = '{16'h5A5A,  1, 1'b0, 1'b0, 0, 1, 2, 0, 6};
    games[5] = '{16'h0F0F,  2, 1'b1, 1'b0, 0, 1, 2, 1, 6};
    games[6] = '{16'h8001,  0, 1'b1, 1'b0, 0, 1, 1, 0, 6};

    repeat (3) @(negedge clock);
    chk("rst_state", int'(state_o), 0);
    chk("rst_sv", int'(show_valid), 0);
    chk("rst_sym", int'(show_sym), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_prog", int'(progress), 0);
    chk("rst_flags", int'({win, lose}), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) play(games[i]);

    // Asynchronous reset in the middle of a display
    sr_t = 16'h2468;
    push_round(sr_t, 1);
    seed  = sr_t;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_state(1, "to_show", ok_t);
    #1 reset = 1'b1;
    #1;
    chk("mid_state", int'(state_o), 0);
    chk("mid_sv", int'(show_valid), 0);
    chk("mid_sym", int'(show_sym), 0);
    chk("mid_level", int'(level), 0);
    chk("mid_prog", int'(progress), 0);
    chk("mid_flags", int'({win, lose}), 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);

    // Idle behaviour in INPUT with manually driven ticks
    sr_t = 16'h7777;
    push_round(sr_t, 1);
    seed  = sr_t;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_state(3, "to_input_idle", ok_t);
    tick_auto = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick_man = 1'b1;
      @(negedge clock);
      tick_man = 1'b0;
      chk("to_hold", int'(state_o), 3);
    end
    tick_man = 1'b1;
    @(negedge clock);
    tick_man = 1'b0;
    chk("to_state", int'(state_o), 6);
    chk("to_lose", int'(lose), 1);
`else
    for (int i = 0; i < 8; i++) begin
      tick_man = 1'b1;
      @(negedge clock);
      tick_man = 1'b0;
    end
    chk("idle_state", int'(state_o), 3);
    chk("idle_lose", int'(lose), 0);
    s_t = model_sym(sr_t, 0);
    btn = onehot((int'(s_t) + 1) % 3);
    @(negedge clock);
    btn = '0;
    chk("idle_wrong", int'(state_o), 6);
`endif
    tick_auto = 1'b1;
    chk("idle_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_engine.md
GENIUS_ENGINE -- requirements
Module: genius_engine

Interface
REQ-001 Parameter NUM_BTN, default 4, meaning number of buttons/symbols; legal range 2..8.
REQ-002 Parameter MAX_LEVEL, default 16, meaning winning sequence length; legal range 2..64.
REQ-003 Parameter SHOW_TICKS, default 4, meaning tick count each symbol is displayed; minimum 1.
REQ-004 Parameter GAP_TICKS, default 1, meaning blank ticks between displayed symbols; minimum 1.
REQ-005 Parameter TIMEOUT_TICKS, default 64, meaning input idle limit in ticks; minimum 1.
REQ-006 Derived widths: SYM_W = max(1, clog2(NUM_BTN)); LVL_W = clog2(MAX_LEVEL+1).
REQ-007 Port clock, input, 1 bit, single clock; all logic on its rising edge.
REQ-008 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 Port tick, input, 1 bit, single-cycle timebase strobe.
REQ-010 Port start, input, 1 bit, single-cycle start pulse.
REQ-011 Port seed, input, 16 bits, sequence seed, sampled on accepted start.
REQ-012 Port btn, input, NUM_BTN bits, debounced single-cycle press pulses.
REQ-013 Port show_valid, output, 1 bit, high while a symbol is displayed.
REQ-014 Port show_sym, output, SYM_W bits, displayed symbol; 0 when show_valid is low.
REQ-015 Port level, output, LVL_W bits, current round length.
REQ-016 Port progress, output, LVL_W bits, correct presses so far in the current round.
REQ-017 Port state_o, output, 3 bits, FSM state encoding.
REQ-018 Port win and port lose, outputs, 1 bit each, sticky result flags.

Function
REQ-019 States: IDLE=0, SHOW_ON=1, SHOW_GAP=2, INPUT=3, LEVEL_UP=4, WIN=5, LOSE=6; all outputs are registered.
REQ-020 Start is accepted in IDLE, WIN and LOSE only, and is ignored in every other state.
REQ-021 Accepted start: seed_r<=seed (16'h0000 is replaced by 16'hACE1); level<=1; progress<=0; win/lose<=0; LFSR<=seed_r; next state SHOW_ON.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left, feedback into bit 0; it advances one step per consumed symbol.
REQ-023 Symbol = LFSR[SYM_W-1:0], minus NUM_BTN if the value is >= NUM_BTN; the symbol is always < NUM_BTN.
REQ-024 Every round replays the sequence from seed_r, so symbol k is identical in every round; no sequence storage.
REQ-025 SHOW_ON: show_valid=1 for SHOW_TICKS ticks, then the LFSR advances and the FSM goes to SHOW_GAP.
REQ-026 SHOW_GAP: show_valid=0 for GAP_TICKS ticks; after `level` symbols the LFSR reloads from seed_r and the FSM goes to INPUT, otherwise it returns to SHOW_ON.
REQ-027 INPUT, btn==0: no action.
REQ-028 INPUT, btn one-hot at the expected symbol: progress++ and the LFSR advances.
REQ-029 INPUT, btn with more than one bit set or the wrong bit: lose<=1 on the next edge; next state LOSE.
REQ-030 INPUT: when progress reaches level, the next state is LEVEL_UP.
REQ-031 Btn pulses outside INPUT are ignored.
REQ-032 LEVEL_UP, one cycle: if level==MAX_LEVEL then win<=1 and next state WIN; otherwise level++, progress<=0, LFSR reload, next state SHOW_ON.
REQ-033 WIN and LOSE hold all outputs until an accepted start.
REQ-034 Tick counters clear on every state entry.
REQ-035 Tick is ignored in INPUT except by the timeout counter.

Reset
REQ-036 Reset forces state IDLE and clears show_valid, show_sym, level, progress, win, lose, all counters, LFSR and seed_r, asynchronously, in any state including mid-round.
REQ-037 The first accepted start is the first rising edge with start high after reset deasserts.

Configuration
REQ-038 Macro GENIUS_TIMEOUT_EN defined: in INPUT, ticks are counted since INPUT entry or the last correct press.
REQ-039 With GENIUS_TIMEOUT_EN, reaching TIMEOUT_TICKS sets lose and moves to LOSE; a press and the final tick in the same cycle count as the press.
REQ-040 Macro GENIUS_TIMEOUT_EN undefined: no timeout counter; INPUT waits indefinitely.

Structure
REQ-041 Package genius_pkg holds the state encoding, LFSR taps, the 16'hACE1 default seed and a width helper function.
REQ-042 Sub-module genius_lfsr (load, step, 16-bit state output) is instantiated once.

Verification
REQ-043 Seed 0 versus seed 16'hACE1 -> identical show_sym streams.
REQ-044 MAX_LEVEL=2, all presses correct -> shows 1 then 2 symbols; win=1 after the 3rd correct press; state_o=5.
REQ-045 Level 1, wrong one-hot press -> lose=1 next cycle; state_o=6; level stays 1.
REQ-046 Two btn bits set at once in INPUT -> LOSE.
REQ-047 Start during SHOW_ON is ignored; start in LOSE restarts with level=1.
REQ-048 GENIUS_TIMEOUT_EN with TIMEOUT_TICKS=4 -> 4 idle ticks give LOSE; reset asserted mid-SHOW_ON -> all outputs 0 and state_o=0 immediately.
